// File: rtl/fec_ctrl_pkg.sv
// Shared types for the FEC instruction-decode stage.
// Holds the opcode map, the control bundle carried from decode to execute,
// and the decode-stage state encoding.
package fec_ctrl_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned CODE_W = 4;

    localparam logic [OPC_W-1:0] OPC_XOR  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_LW   = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_SW   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_MOV  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_PUT  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SL   = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_SR   = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_INC  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_DEC  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_DONE = 5'b01111;

    // Control bundle; funct is the native 4-bit ALU code.
    typedef struct packed {
        logic              op;
        logic [CODE_W-1:0] funct;
        logic              reg_write;
        logic              reg_dest;
        logic              branch_en;
        logic              mem_write;
        logic              mem_read;
        logic              done;
        logic              illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } dec_state_t;

endpackage

// File: rtl/ctrl_decode_lut.sv
// Purely combinational opcode -> control bundle mapping.
// Ports:
//   opcode_i  5-bit opcode field
//   ctrl_o    fully defined control bundle (unused fields are 0)
module ctrl_decode_lut
    import fec_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if (opcode_i[OPC_W-1]) begin
            // Any opcode with the top bit set is bne.
            ctrl_o.op        = 1'b1;
            ctrl_o.branch_en = 1'b1;
        end else begin
            case (opcode_i)
                OPC_XOR, OPC_MOV, OPC_ADD, OPC_SUB, OPC_SL, OPC_SR, OPC_AND: begin
                    ctrl_o.funct     = opcode_i[CODE_W-1:0];
                    ctrl_o.reg_write = 1'b1;
                end
                OPC_LW: begin
                    ctrl_o.funct     = opcode_i[CODE_W-1:0];
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.mem_read  = 1'b1;
                end
                OPC_SW: begin
                    ctrl_o.funct     = opcode_i[CODE_W-1:0];
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dest  = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                end
                OPC_PUT, OPC_INC, OPC_DEC: begin
                    ctrl_o.funct     = opcode_i[CODE_W-1:0];
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dest  = 1'b1;
                end
                OPC_DONE: ctrl_o.done = 1'b1;
                // Only 01100..01110 remain here.
                default:  ctrl_o.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered valid/ready instruction-decode stage.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready/in_instr   instruction input handshake
//   out_valid/out_ready          control bundle output handshake
//   out_*                        registered control bundle and operand
//   halted, err_illegal          sticky status
//   instr_count                  saturating accepted-instruction counter
module ctrl_decode_stage
    import fec_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W      = 9,
    parameter int unsigned FUNCT_W      = 4,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_op,
    output logic [FUNCT_W-1:0] out_funct,
    output logic               out_reg_write,
    output logic               out_reg_dest,
    output logic               out_branch_en,
    output logic               out_mem_write,
    output logic               out_mem_read,
    output logic               out_done,
    output logic               out_illegal,
    output logic [INSTR_W-6:0] out_operand,
    output logic               halted,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int unsigned OPD_W = INSTR_W - OPC_W;
    localparam int unsigned BUB_W = (LOAD_BUBBLES > 1) ? $clog2(LOAD_BUBBLES + 1) : 1;

    dec_state_t         state_q, state_d;
    logic [BUB_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [OPD_W-1:0]   opd_q, opd_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    ctrl_t              dec_ctrl;
    logic               in_xfer;
    logic               out_xfer;

    ctrl_decode_lut u_lut (
        .opcode_i (in_instr[INSTR_W-1 -: OPC_W]),
        .ctrl_o   (dec_ctrl)
    );

    // Ready depends only on state and downstream ready, never on in_valid.
    assign in_ready = (state_q == RUN) & (~valid_q | out_ready);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = valid_q & out_ready;

    // Next-state: FSM, bubble counter, output register, status.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        opd_d    = opd_q;
        halted_d = halted_q;
        err_d    = err_q;
        count_d  = count_q;

        case (state_q)
            RUN: begin
                if (in_xfer) begin
                    if (dec_ctrl.done) begin
                        state_d = HALT;
                    end else if (dec_ctrl.mem_read && (LOAD_BUBBLES > 0)) begin
                        state_d = BUBBLE;
                        cnt_d   = BUB_W'(LOAD_BUBBLES);
                    end
                end
            end
            BUBBLE: begin
                if (cnt_q <= BUB_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - BUB_W'(1);
                end
            end
            HALT:    state_d = HALT;
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        // A new input always wins over draining the old bundle.
        if (in_xfer) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            opd_d   = in_instr[OPD_W-1:0];
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
            if (dec_ctrl.done) begin
                halted_d = 1'b1;
            end
            if (dec_ctrl.illegal) begin
                err_d = 1'b1;
            end
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            opd_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            opd_q    <= opd_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_op        = ctrl_q.op;
    assign out_funct     = FUNCT_W'(ctrl_q.funct);
    assign out_reg_write = ctrl_q.reg_write;
    assign out_reg_dest  = ctrl_q.reg_dest;
    assign out_branch_en = ctrl_q.branch_en;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_done      = ctrl_q.done;
    assign out_illegal   = ctrl_q.illegal;
    assign out_operand   = opd_q;
    assign halted        = halted_q;
    assign err_illegal   = err_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed scenarios plus random traffic
// against a behavioural model of the opcode table and handshake rules.
module tb_ctrl_decode_stage;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned FUNCT_W = 4;
    localparam int unsigned LB      = 2;
    localparam int unsigned CNT_W   = 6;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       op;
        logic [3:0] funct;
        logic       reg_write;
        logic       reg_dest;
        logic       branch_en;
        logic       mem_write;
        logic       mem_read;
        logic       done;
        logic       illegal;
        logic [3:0] operand;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_op;
    logic [FUNCT_W-1:0] out_funct;
    logic               out_reg_write, out_reg_dest, out_branch_en;
    logic               out_mem_write, out_mem_read, out_done, out_illegal;
    logic [INSTR_W-6:0] out_operand;
    logic               halted, err_illegal;
    logic [CNT_W-1:0]   instr_count;

    ctrl_decode_stage #(
        .INSTR_W(INSTR_W), .FUNCT_W(FUNCT_W), .LOAD_BUBBLES(LB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct(out_funct),
        .out_reg_write(out_reg_write), .out_reg_dest(out_reg_dest),
        .out_branch_en(out_branch_en), .out_mem_write(out_mem_write),
        .out_mem_read(out_mem_read), .out_done(out_done), .out_illegal(out_illegal),
        .out_operand(out_operand),
        .halted(halted), .err_illegal(err_illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int   tests  = 0;
    int   errors = 0;
    exp_t sbq[$];

    // Model state
    int   m_cnt  = 0;
    bit   m_halt = 1'b0;
    bit   m_err  = 1'b0;
    int   m_bub  = 0;
    bit   m_oval = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode from the opcode table.
    function automatic exp_t ref_dec(input logic [INSTR_W-1:0] ins);
        exp_t       e;
        logic [4:0] opc;
        int         n;
        e = '0;
        opc = ins[8:4];
        n = int'(opc);
        e.operand = ins[3:0];
        if (n >= 16) begin
            e.op = 1'b1;
            e.branch_en = 1'b1;
        end else if (n <= 11) begin
            e.funct     = opc[3:0];
            e.reg_write = 1'b1;
            e.reg_dest  = (n == 2) || (n == 4) || (n == 9) || (n == 10);
            e.mem_write = (n == 2);
            e.mem_read  = (n == 1);
        end else if (n == 15) begin
            e.done = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t act_bundle();
        exp_t a;
        a.op = out_op;             a.funct = out_funct;
        a.reg_write = out_reg_write; a.reg_dest = out_reg_dest;
        a.branch_en = out_branch_en; a.mem_write = out_mem_write;
        a.mem_read = out_mem_read; a.done = out_done;
        a.illegal = out_illegal;   a.operand = out_operand;
        return a;
    endfunction

    // One clock of stimulus; checks status against the model and advances it.
    task automatic do_cycle(input bit v, input logic [INSTR_W-1:0] ins, input bit ordy,
                            output bit acc);
        bit   exp_rdy;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        #3;
        exp_rdy = !m_halt && (m_bub == 0) && (!m_oval || ordy);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_oval));
        chk("instr_count", 64'(instr_count), 64'(m_cnt));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("err_illegal", 64'(err_illegal), 64'(m_err));
        acc = v && exp_rdy;
        if (acc) begin
            e = ref_dec(ins);
            sbq.push_back(e);
            if (m_cnt < CNT_MAX) m_cnt++;
            if (e.done) m_halt = 1'b1;
            if (e.illegal) m_err = 1'b1;
            if (e.mem_read && LB > 0) m_bub = LB;
        end else if (m_bub > 0) begin
            m_bub--;
        end
        m_oval = acc || (m_oval && !ordy);
    endtask

    task automatic send(input logic [INSTR_W-1:0] ins, input bit ordy);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) do_cycle(1'b1, ins, ordy, acc);
        if (!acc) begin
            tests++;
            errors++;
            $display("FAIL send_timeout: got not-accepted expected accepted for %0h", ins);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, ordy, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bundle", 64'(act_bundle()), 64'd0);
        chk("rst_instr_count", 64'(instr_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err_illegal", 64'(err_illegal), 64'd0);
        sbq.delete();
        m_cnt = 0; m_halt = 1'b0; m_err = 1'b0; m_bub = 0; m_oval = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [4:0] opc);
        logic [3:0] opd;
        opd = 4'($urandom);
        return {opc, opd};
    endfunction

    // Monitor: compare the presented bundle whenever the DUT shows out_valid.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL sb_empty: got bundle %0h expected none", act_bundle());
            end else if (out_ready) begin
                chk("bundle", 64'(act_bundle()), 64'(sbq.pop_front()));
            end else begin
                chk("bundle_hold", 64'(act_bundle()), 64'(sbq[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        logic [INSTR_W-1:0] ins;
        do_reset();

        // Back-to-back ALU ops.
        send(mk(5'b00000), 1'b1);
        send(mk(5'b00101), 1'b1);
        send(mk(5'b01000), 1'b1);
        idle(2, 1'b1);

        // Load followed by add: bubble window.
        send(mk(5'b00001), 1'b1);
        send(mk(5'b00101), 1'b1);
        idle(1, 1'b1);

        // Branch class.
        send(9'b1_0101_0110, 1'b1);

        // Illegal then normal.
        send(mk(5'b01101), 1'b1);
        send(mk(5'b00000), 1'b1);
        idle(2, 1'b1);

        // Downstream stall then simultaneous replace.
        send(mk(5'b00101), 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, mk(5'b00000), 1'b0, acc);
        do_cycle(1'b1, mk(5'b01001), 1'b1, acc);
        idle(2, 1'b1);

        // Random traffic with resets between blocks (possibly mid-bubble).
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 80; i++) begin
                ins = INSTR_W'($urandom);
                if (ins[8:4] == 5'b01111 && $urandom_range(0, 5) != 0) ins[8:4] = 5'b00011;
                do_cycle(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 3) != 0), acc);
            end
            do_reset();
        end

        // Saturation of the counter.
        for (int i = 0; i < CNT_MAX + 4; i++) send(mk(5'b00110), 1'b1);
        idle(2, 1'b1);
        do_reset();

        // done under downstream stall, then halt and reset out of it.
        send(mk(5'b00011), 1'b1);
        idle(1, 1'b1);
        send(mk(5'b01111), 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, mk(5'b00000), 1'b0, acc);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, mk(5'b00000), 1'b1, acc);
        do_reset();
        send(mk(5'b00000), 1'b1);
        idle(3, 1'b1);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, handshaked instruction-decode stage for the FEC processor. It sits between instruction fetch and the register-file/ALU stage, and turns each instruction word into a control bundle one cycle later under a valid/ready handshake. It generalises the plain combinational control decode to a parametrised instruction width, with several additions:
- fully defined outputs for every opcode;
- sticky illegal-opcode and halt reporting;
- configurable load-use bubble insertion;
- a retired-instruction counter.

## Interface
- INSTR_W, 9: instruction word width; opcode is instr[INSTR_W-1 -: 5], operand is instr[INSTR_W-6:0].
- FUNCT_W, 4: ALU function field width; must be ≥4.
- LOAD_BUBBLES, 1: stall cycles inserted after every accepted lw; 0 disables the BUBBLE state.
- CNT_W, 16: width of the decoded-instruction counter.
- clk  in  1  single clock; all flops rise on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  INSTR_W  instruction word.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  downstream consumes bundle.
- out_op  out  1  1 = branch-class instruction.
- out_funct  out  FUNCT_W  ALU function, zero-extended from the 4-bit code.
- out_reg_write, out_reg_dest, out_branch_en, out_mem_write, out_mem_read, out_done, out_illegal  out  1 each  control flags.
- out_operand  out  INSTR_W-5  operand bits, passed through unchanged.
- halted  out  1  sticky; set when done is accepted.
- err_illegal  out  1  sticky; set when an illegal opcode is accepted.
- instr_count  out  CNT_W  accepted instructions, saturating at all-ones.

## Operation
- Opcode map (op, funct, reg_write, reg_dest, branch_en, mem_write, mem_read):
  - xor 00000: 0,0,1,0,0,0,0
  - lw 00001: 0,1,1,0,0,0,1
  - sw 00010: 0,2,1,1,0,1,0
  - mov 00011: 0,3,1,0,0,0,0
  - put 00100: 0,4,1,1,0,0,0
  - add 00101: 0,5,1,0,0,0,0
  - sub 00110: 0,6,1,0,0,0,0
  - sl 00111: 0,7,1,0,0,0,0
  - sr 01000: 0,8,1,0,0,0,0
  - inc 01001: 0,9,1,1,0,0,0
  - dec 01010: 0,10,1,1,0,0,0
  - and 01011: 0,11,1,0,0,0,0
  - bne 1xxxx: 1,0,0,0,1,0,0
  - done 01111: all flags 0, done=1
  - illegal 01100/01101/01110: all flags 0, illegal=1
- No X values are ever driven. Any field unused by an opcode is 0.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- in_ready = (state==RUN) & (!out_valid | out_ready).
- State machine (enum in package):
  - RUN: on accepting lw with LOAD_BUBBLES>0, go to BUBBLE with cnt=LOAD_BUBBLES. On accepting done, go to HALT. Otherwise stay.
  - BUBBLE: in_ready=0; cnt decrements each cycle; go to RUN in the cycle cnt reaches 1.
  - HALT: in_ready=0 permanently; only rst_n exits.
- Output register:
  - Loads the decoded bundle on every input transfer.
  - Clears out_valid on an out transfer with no simultaneous input transfer.
  - Holds stable while out_valid & !out_ready.
- Sticky flags and counter:
  - halted sets in the cycle the done instruction is accepted.
  - err_illegal sets on illegal acceptance.
  - instr_count increments on every input transfer, including done and illegal, and saturates at 2^CNT_W-1.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1, excluding bubbles.
- lw costs 1+LOAD_BUBBLES input cycles.
- Simultaneous in and out transfer with out_valid=1: new bundle replaces the old one; out_valid stays 1.
- in_ready is combinational from out_ready and state only, never from in_valid.
- done accepted while downstream stalls: in_ready already drops the next cycle; the done bundle waits in the register until consumed.
- Reset, asserted at any time including mid-BUBBLE or HALT, drives:
  - state=RUN, cnt=0;
  - out_valid=0, all out_* flags, out_funct and out_operand =0;
  - halted=0, err_illegal=0, instr_count=0.
- in_ready may rise in the first clock after rst_n deasserts.

## Structure
- Package fec_ctrl_pkg holds:
  - opcode localparams;
  - ctrl_t packed struct (op, funct, reg_write, reg_dest, branch_en, mem_write, mem_read, done, illegal);
  - dec_state_t enum {RUN, BUBBLE, HALT}.
- Sub-module ctrl_decode_lut is the purely combinational opcode → ctrl_t mapping, reusable and separately testable.
- ctrl_decode_stage holds the FSM, bubble counter, output register, sticky flags and instruction counter.

## Test plan
- Stream xor, add, sr with out_ready=1:
  - out_valid from cycle 1;
  - funct 0,5,8, each with reg_write=1;
  - instr_count=3;
  - in_ready never drops.
- lw then add with LOAD_BUBBLES=2:
  - in_ready low for exactly 2 cycles after the lw transfer;
  - lw bundle shows mem_read=1, funct=1;
  - add accepted on the 3rd cycle.
- in_instr=9'b1_0101_0110 (bne) → op=1, branch_en=1, funct=0, reg_write=0, out_operand=4'b0110.
- Opcode 01101:
  - illegal=1 and all flags 0 in the bundle;
  - err_illegal stays 1 afterwards;
  - a following xor still decodes normally.
- done with out_ready=0 for 3 cycles:
  - bundle held stable with done=1;
  - halted=1, in_ready=0 indefinitely;
  - rst_n pulse mid-HALT restores RUN, counter 0, halted 0.
- Hold out_ready=0 after one accepted instruction:
  - in_ready=0, bundle unchanged;
  - release with in_valid=1 → replacement in the same cycle, out_valid stays 1.
